// File: rtl/timer_ctrl_fsm.sv
// Button front end for the digital timer: sync, debounce and edge detect, then a Moore run/pause/clear FSM.
// Optional long-press-to-clear on start/stop in PAUSE is enabled by defining TIMER_CTRL_LONG_PRESS_CLR_EN.
module timer_ctrl_fsm #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic       sys_clk,
  input  logic       int_reset_b,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       timer_pause,
  output logic       timer_clear,
  output logic       timer_running,
  output logic [1:0] timer_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
    $error("timer_ctrl_fsm: DEBOUNCE_CYCLES must be >= 2 and LONG_PRESS_CYCLES > DEBOUNCE_CYCLES");
  end

  state_t          state;
  state_t          state_next;
  logic [1:0]      raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      db_level;
  logic [1:0]      db_level_d;
  logic [CW-1:0]   db_cnt [2];
  logic [1:0]      press;
  logic            start_press;
  logic            clear_press;
  logic            start_toggle;
  logic            force_clear;

  // Bit 0 is start/stop, bit 1 is clear.
  assign raw = {btn_clear, btn_start_stop};

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      sync1      <= '0;
      sync2      <= '0;
      db_level   <= '0;
      db_level_d <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1      <= raw;
      sync2      <= sync1;
      db_level_d <= db_level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != db_level[i]) begin
          if (db_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
            db_level[i] <= ~db_level[i];
            db_cnt[i]   <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + CW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign press       = db_level & ~db_level_d;
  assign start_press = press[0];
  assign clear_press = press[1];

`ifdef TIMER_CTRL_LONG_PRESS_CLR_EN
  localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);

  logic          hold_active;
  logic [HW-1:0] hold_cnt;
  logic          long_fire;
  logic          release_fire;

  assign long_fire    = hold_active && db_level[0] && (hold_cnt == HW'(LONG_PRESS_CYCLES - 1));
  assign release_fire = hold_active && !db_level[0];

  // A press taken in PAUSE is deferred: release resumes, a long hold clears.
  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      hold_active <= 1'b0;
      hold_cnt    <= '0;
    end else if (state == PAUSE && start_press && !clear_press) begin
      hold_active <= 1'b1;
      hold_cnt    <= '0;
    end else if (hold_active) begin
      if (long_fire || release_fire || clear_press) begin
        hold_active <= 1'b0;
        hold_cnt    <= '0;
      end else begin
        hold_cnt <= hold_cnt + HW'(1);
      end
    end
  end

  assign start_toggle = (state == PAUSE) ? release_fire : start_press;
  assign force_clear  = long_fire;
`else
  assign start_toggle = start_press;
  assign force_clear  = 1'b0;
`endif

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) state <= IDLE;
    else              state <= state_next;
  end

  // Clear outranks start when both presses land in the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (clear_press)                    state_next = CLEAR;
             else if (start_toggle)              state_next = RUN;
      RUN:   if (clear_press)                    state_next = CLEAR;
             else if (start_toggle)              state_next = PAUSE;
      PAUSE: if (clear_press || force_clear)     state_next = CLEAR;
             else if (start_toggle)              state_next = RUN;
      CLEAR:                                     state_next = IDLE;
      default:                                   state_next = IDLE;
    endcase
  end

  always_comb begin
    timer_pause   = 1'b1;
    timer_clear   = 1'b0;
    timer_running = 1'b0;
    case (state)
      RUN: begin
        timer_pause   = 1'b0;
        timer_running = 1'b1;
      end
      CLEAR: begin
        timer_pause = 1'b0;
        timer_clear = 1'b1;
      end
      default: ;
    endcase
  end

  assign timer_state = state;

endmodule

// File: tb/tb_timer_ctrl_fsm.sv
// Directed bench for timer_ctrl_fsm with DEBOUNCE_CYCLES=4 (state change on edge 7 after first sampling edge).
module tb_timer_ctrl_fsm;
  localparam int DB  = 4;
  localparam int LAT = DB + 3;

  logic       sys_clk        = 1'b0;
  logic       int_reset_b    = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear      = 1'b0;
  logic       timer_pause;
  logic       timer_clear;
  logic       timer_running;
  logic [1:0] timer_state;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int bounce_len [20] = '{1, 2, 3, 1, 3, 2, 1, 1, 3, 3, 2, 1, 2, 3, 1, 2, 3, 1, 2, 3};

  timer_ctrl_fsm #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(16)
  ) dut (
    .sys_clk       (sys_clk),
    .int_reset_b   (int_reset_b),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .timer_pause   (timer_pause),
    .timer_clear   (timer_clear),
    .timer_running (timer_running),
    .timer_state   (timer_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic p, input logic c, input logic r,
                         input logic [1:0] s);
    chk({tag, ".pause"}, {1'b0, timer_pause}, {1'b0, p});
    chk({tag, ".clear"}, {1'b0, timer_clear}, {1'b0, c});
    chk({tag, ".running"}, {1'b0, timer_running}, {1'b0, r});
    chk({tag, ".state"}, timer_state, s);
  endtask

  // Advance n rising edges, then park on the following falling edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  task automatic press_start();
    btn_start_stop = 1'b1;
    cyc(LAT);
    btn_start_stop = 1'b0;
    cyc(12);
  endtask

  initial begin
    #23;
    chk_out("reset", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    cyc(50);
    chk_out("idle_50", 1'b1, 1'b0, 1'b0, 2'd0);

    btn_start_stop = 1'b1;
    cyc(LAT - 1);
    chk_out("start_edge6", 1'b1, 1'b0, 1'b0, 2'd0);
    cyc(1);
    chk_out("start_run", 1'b0, 1'b0, 1'b1, 2'd1);
    cyc(20 - LAT);
    chk("start_held_run", timer_state, 2'd1);
    btn_start_stop = 1'b0;
    cyc(12);
    chk_out("run_after_release", 1'b0, 1'b0, 1'b1, 2'd1);

    btn_start_stop = 1'b1;
    cyc(LAT);
    chk_out("second_press_pause", 1'b1, 1'b0, 1'b0, 2'd2);
    btn_start_stop = 1'b0;
    cyc(12);

    press_start();
    chk("third_press_run", timer_state, 2'd1);

    btn_clear = 1'b1;
    cyc(LAT - 1);
    chk("clr_pre", timer_state, 2'd1);
    cyc(1);
    chk_out("clr_pulse", 1'b0, 1'b1, 1'b0, 2'd3);
    cyc(1);
    chk_out("clr_idle", 1'b1, 1'b0, 1'b0, 2'd0);
    btn_clear = 1'b0;
    cyc(12);
    chk_out("clr_settled", 1'b1, 1'b0, 1'b0, 2'd0);

    for (int i = 0; i < 20; i++) begin
      btn_start_stop = (i % 2 == 0);
      for (int k = 0; k < bounce_len[i]; k++) begin
        cyc(1);
        chk("bounce_state", timer_state, 2'd0);
      end
    end
    btn_start_stop = 1'b0;
    cyc(12);
    chk_out("bounce_after", 1'b1, 1'b0, 1'b0, 2'd0);

    press_start();
    press_start();
    chk("pre_simul_pause", timer_state, 2'd2);
    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    cyc(LAT - 1);
    chk("simul_pre", timer_state, 2'd2);
    cyc(1);
    chk_out("simul_clear", 1'b0, 1'b1, 1'b0, 2'd3);
    cyc(1);
    chk_out("simul_idle", 1'b1, 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      chk("simul_no_run", timer_state, 2'd0);
    end
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    cyc(12);
    chk("simul_settled", timer_state, 2'd0);

    btn_start_stop = 1'b1;
    cyc(LAT);
    chk("pre_reset_run", timer_state, 2'd1);
    #2 int_reset_b = 1'b0;
    #1 chk_out("async_rst_run", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    cyc(4);
    chk("mid_debounce", timer_state, 2'd0);
    #2 int_reset_b = 1'b0;
    #1 chk_out("async_rst_db", 1'b1, 1'b0, 1'b0, 2'd0);
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    cyc(LAT - 1);
    chk("relatch_pre", timer_state, 2'd0);
    cyc(1);
    chk_out("relatch_run", 1'b0, 1'b0, 1'b1, 2'd1);
    cyc(20);
    chk("relatch_held", timer_state, 2'd1);
    btn_start_stop = 1'b0;
    cyc(12);
    chk_out("final_run", 1'b0, 1'b0, 1'b1, 2'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
